// File: rtl/jtag_host_pkg.sv
// jtag_host_pkg: shared types and constants for the jtag_host block.
//   cmd_type_t : host command encodings (RESET, SHIFT_IR, SHIFT_DR, reserved).
//   state_t    : sequencing FSM states, also exported on host_dbgState.
//   RST_TCKS / DR_PRE / IR_PRE / POST : TCK counts of the fixed TMS segments.
package jtag_host_pkg;

  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_IR    = 2'b01,
    CMD_DR    = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_type_t;

  typedef enum logic [2:0] {
    ST_RST_SEQ = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PRE     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_POST    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // TMS segment lengths, in TCKs.
  localparam logic [3:0] RST_TCKS = 4'd6;  // 1,1,1,1,1,0
  localparam logic [3:0] DR_PRE   = 4'd3;  // 1,0,0
  localparam logic [3:0] IR_PRE   = 4'd4;  // 1,1,0,0
  localparam logic [3:0] POST     = 4'd2;  // 1,0

endpackage

// File: rtl/jtag_host_tckgen.sv
// jtag_host_tckgen: TCK divider for jtag_host.
//   host_clk, host_rstn : host clock / async active-low reset
//   en                  : run the divider (held by the FSM while TCKs are due)
//   tck                 : JTAG clock, CLK_DIV cycles low then CLK_DIV cycles high
//   fall                : one-cycle strobe on the last high cycle; the edge that
//                         ends it drops TCK and launches the next TMS/TDI
//   sample              : one-cycle strobe on the last high cycle (TDO sample)
module jtag_host_tckgen #(
  parameter int CLK_DIV = 2
) (
  input  logic host_clk,
  input  logic host_rstn,
  input  logic en,
  output logic tck,
  output logic fall,
  output logic sample
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tck_q;
  logic          phase_end;

  assign phase_end = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge host_clk or negedge host_rstn) begin
    if (!host_rstn) begin
      cnt   <= '0;
      tck_q <= 1'b0;
    end else if (en) begin
      if (phase_end) begin
        cnt   <= '0;
        tck_q <= ~tck_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign tck    = tck_q;
  // The last high cycle is both the TDO sample point and the cycle whose
  // closing edge drops TCK, so the two strobes coincide.
  assign fall   = en & tck_q & phase_end;
  assign sample = en & tck_q & phase_end;

endmodule

// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator with a command/response host interface.
//   host_clk, host_rstn        : host clock / async active-low reset
//   host_cmdValid/host_cmdReady: command handshake; a command transfers on a
//                                rising host_clk edge where both are 1
//   host_cmdType/Len/Data      : command type, shift length-1, TDI bits (LSB first)
//   host_rspValid/host_rspData : one-cycle completion pulse and captured TDO bits
//   host_tck/tms/tdi/tdo       : JTAG pins
//   host_dbgState              : current FSM state (state_t encoding)
// Optional feature macro: JTAG_HOST_TDO_SYNC_EN (two-flop TDO synchronizer,
// requires CLK_DIV >= 3).
module jtag_host
  import jtag_host_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        host_clk,
  input  logic        host_rstn,
  input  logic        host_cmdValid,
  output logic        host_cmdReady,
  input  logic [1:0]  host_cmdType,
  input  logic [3:0]  host_cmdLen,
  input  logic [15:0] host_cmdData,
  output logic        host_rspValid,
  output logic [15:0] host_rspData,
  output logic        host_tck,
  output logic        host_tms,
  output logic        host_tdi,
  input  logic        host_tdo,
  output logic [2:0]  host_dbgState
);

  state_t      state;
  cmd_type_t   cmd_type;
  logic [3:0]  cmd_len;
  logic [15:0] cmd_data;
  logic [3:0]  bit_cnt;
  logic [3:0]  bit_nxt;
  logic [3:0]  pre_last;
  logic [15:0] cap;
  logic        auto_rst;
  logic        tms_q;
  logic        tdi_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic        tck_en;
  logic        tck_fall;
  logic        tck_sample;
  logic        tdo_s;

`ifdef JTAG_HOST_TDO_SYNC_EN
  logic [1:0] tdo_sync;

  always_ff @(posedge host_clk or negedge host_rstn) begin
    if (!host_rstn) tdo_sync <= 2'b00;
    else            tdo_sync <= {tdo_sync[0], host_tdo};
  end

  assign tdo_s = tdo_sync[1];

  // The synchronized value must have settled by the sample point.
  if (CLK_DIV < 3) begin : g_bad_clk_div
    $error("jtag_host: CLK_DIV must be >= 3 with JTAG_HOST_TDO_SYNC_EN");
  end
`else
  assign tdo_s = host_tdo;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("jtag_host: CLK_DIV must be >= 1");
  end
`endif

  assign tck_en = (state == ST_RST_SEQ) || (state == ST_PRE) ||
                  (state == ST_SHIFT)   || (state == ST_POST);

  jtag_host_tckgen #(.CLK_DIV(CLK_DIV)) u_tckgen (
    .host_clk  (host_clk),
    .host_rstn (host_rstn),
    .en        (tck_en),
    .tck       (host_tck),
    .fall      (tck_fall),
    .sample    (tck_sample)
  );

  assign bit_nxt  = bit_cnt + 4'd1;
  assign pre_last = (cmd_type == CMD_IR) ? (IR_PRE - 4'd1) : (DR_PRE - 4'd1);

  // Each TCK's TMS/TDI is launched on the edge that ends the previous TCK
  // (tck_fall). The first TCK of a sequence is launched by the edge that
  // enters the sequence (reset release or command accept), which is why
  // tms is preset to 1 there.
  always_ff @(posedge host_clk or negedge host_rstn) begin
    if (!host_rstn) begin
      state       <= ST_RST_SEQ;
      auto_rst    <= 1'b1;
      cmd_type    <= CMD_RESET;
      cmd_len     <= 4'd0;
      cmd_data    <= 16'd0;
      bit_cnt     <= 4'd0;
      cap         <= 16'd0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_cmdValid && ready_q) begin
            ready_q  <= 1'b0;
            cmd_type <= cmd_type_t'(host_cmdType);
            cmd_len  <= host_cmdLen;
            cmd_data <= host_cmdData;
            cap      <= 16'd0;
            bit_cnt  <= 4'd0;
            auto_rst <= 1'b0;
            case (cmd_type_t'(host_cmdType))
              CMD_RSVD: state <= ST_DONE;
              CMD_RESET: begin
                state <= ST_RST_SEQ;
                tms_q <= 1'b1;
              end
              default: begin
                state <= ST_PRE;
                tms_q <= 1'b1;
              end
            endcase
          end
        end

        ST_RST_SEQ: begin
          if (tck_fall) begin
            if (bit_cnt == RST_TCKS - 4'd1) begin
              state   <= ST_DONE;
              bit_cnt <= 4'd0;
            end else begin
              bit_cnt <= bit_nxt;
              tms_q   <= (bit_nxt < RST_TCKS - 4'd1);
            end
          end
        end

        ST_PRE: begin
          if (tck_fall) begin
            if (bit_cnt == pre_last) begin
              state   <= ST_SHIFT;
              bit_cnt <= 4'd0;
              tms_q   <= (cmd_len == 4'd0);
              tdi_q   <= cmd_data[0];
            end else begin
              bit_cnt <= bit_nxt;
              // Only the IR header has a second 1 (Select-DR -> Select-IR).
              tms_q   <= (cmd_type == CMD_IR) && (bit_cnt == 4'd0);
            end
          end
        end

        ST_SHIFT: begin
          if (tck_sample) cap[bit_cnt] <= tdo_s;
          if (tck_fall) begin
            if (bit_cnt == cmd_len) begin
              state   <= ST_POST;
              bit_cnt <= 4'd0;
              tms_q   <= 1'b1;
              tdi_q   <= 1'b0;
            end else begin
              bit_cnt <= bit_nxt;
              tdi_q   <= cmd_data[bit_nxt];
              // The last shift TCK carries TMS=1 to leave the shift state.
              tms_q   <= (bit_nxt == cmd_len);
            end
          end
        end

        ST_POST: begin
          if (tck_fall) begin
            if (bit_cnt == POST - 4'd1) begin
              state   <= ST_DONE;
              bit_cnt <= 4'd0;
            end else begin
              bit_cnt <= bit_nxt;
              tms_q   <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          ready_q  <= 1'b1;
          auto_rst <= 1'b0;
          // The power-on reset sequence completes silently.
          if (!auto_rst) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cap;
          end
        end

        default: state <= ST_RST_SEQ;
      endcase
    end
  end

  assign host_cmdReady = ready_q;
  assign host_rspValid = rsp_valid_q;
  assign host_rspData  = rsp_data_q;
  assign host_tms      = tms_q;
  assign host_tdi      = tdi_q;
  assign host_dbgState = state;

endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: bench for jtag_host with a behavioural TAP (4-bit IR capturing
// 0x1, 8-bit DR capturing 0x3C), a response scoreboard and per-TCK TMS/TDI logs.
module tb_jtag_host;

  localparam int C = 2;

  logic        host_clk;
  logic        host_rstn;
  logic        host_cmdValid;
  logic        host_cmdReady;
  logic [1:0]  host_cmdType;
  logic [3:0]  host_cmdLen;
  logic [15:0] host_cmdData;
  logic        host_rspValid;
  logic [15:0] host_rspData;
  logic        host_tck;
  logic        host_tms;
  logic        host_tdi;
  logic        host_tdo;
  logic [2:0]  host_dbgState;

  jtag_host #(.CLK_DIV(C)) dut (
    .host_clk      (host_clk),
    .host_rstn     (host_rstn),
    .host_cmdValid (host_cmdValid),
    .host_cmdReady (host_cmdReady),
    .host_cmdType  (host_cmdType),
    .host_cmdLen   (host_cmdLen),
    .host_cmdData  (host_cmdData),
    .host_rspValid (host_rspValid),
    .host_rspData  (host_rspData),
    .host_tck      (host_tck),
    .host_tms      (host_tms),
    .host_tdi      (host_tdi),
    .host_tdo      (host_tdo),
    .host_dbgState (host_dbgState)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  initial host_clk = 1'b0;
  always #5 host_clk = ~host_clk;
  always @(posedge host_clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural TAP model ----------------
  localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3,
                         SH_DR = 4'd4, EX1_DR = 4'd5, PAU_DR = 4'd6, EX2_DR = 4'd7,
                         UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
                         EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      TLR:    return tms ? TLR    : RTI;
      RTI:    return tms ? SEL_DR : RTI;
      SEL_DR: return tms ? SEL_IR : CAP_DR;
      CAP_DR: return tms ? EX1_DR : SH_DR;
      SH_DR:  return tms ? EX1_DR : SH_DR;
      EX1_DR: return tms ? UPD_DR : PAU_DR;
      PAU_DR: return tms ? EX2_DR : PAU_DR;
      EX2_DR: return tms ? UPD_DR : SH_DR;
      UPD_DR: return tms ? SEL_DR : RTI;
      SEL_IR: return tms ? TLR    : CAP_IR;
      CAP_IR: return tms ? EX1_IR : SH_IR;
      SH_IR:  return tms ? EX1_IR : SH_IR;
      EX1_IR: return tms ? UPD_IR : PAU_IR;
      PAU_IR: return tms ? EX2_IR : PAU_IR;
      EX2_IR: return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;  // UPD_IR
    endcase
  endfunction

  logic [3:0] tap   = TLR;
  logic [7:0] dr_sr = 8'h00;
  logic [3:0] ir_sr = 4'h0;
  logic [3:0] ir    = 4'h0;
  logic       tdo_m = 1'b0;
  logic       tdo_tie = 1'b0;

  assign host_tdo = tdo_tie ? 1'b1 : tdo_m;

  always @(posedge host_tck) begin
    case (tap)
      CAP_DR: dr_sr = 8'h3C;
      SH_DR:  dr_sr = {host_tdi, dr_sr[7:1]};
      CAP_IR: ir_sr = 4'h1;
      SH_IR:  ir_sr = {host_tdi, ir_sr[3:1]};
      UPD_IR: ir = ir_sr;
      default: ;
    endcase
    tap = tap_next(tap, host_tms);
  end

  always @(negedge host_tck)
    tdo_m = (tap == SH_DR) ? dr_sr[0] : (tap == SH_IR) ? ir_sr[0] : 1'b0;

  // ---------------- TCK logs ----------------
  int   tck_total = 0;
  logic tms_hist [0:255];
  logic tdi_hist [0:255];

  always @(posedge host_tck) begin
    tms_hist[tck_total % 256] = host_tms;
    tdi_hist[tck_total % 256] = host_tdi;
    tck_total++;
  end

  function automatic logic [31:0] tms_bits(input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n && i < 32; i++) v[i] = tms_hist[(base + i) % 256];
    return v;
  endfunction

  function automatic logic [31:0] tdi_bits(input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n && i < 32; i++) v[i] = tdi_hist[(base + i) % 256];
    return v;
  endfunction

  // ---------------- scoreboard / response monitor ----------------
  logic [15:0] exp_q[$];
  int rsp_cnt = 0;
  int rsp_cyc_log [0:63];

  always @(negedge host_clk) begin
    if (host_rspValid) begin
      rsp_cyc_log[rsp_cnt % 64] = cyc;
      rsp_cnt++;
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else                   check("rsp_data", 32'(host_rspData), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc;

  task automatic reset_seq();
    int base;
    int n0;
    int n;
    @(negedge host_clk);
    host_rstn = 1'b0;
    host_cmdValid = 1'b0;
    repeat (3) @(negedge host_clk);
    check("rst_tck",      32'(host_tck),      32'd0);
    check("rst_tms",      32'(host_tms),      32'd1);
    check("rst_tdi",      32'(host_tdi),      32'd0);
    check("rst_ready",    32'(host_cmdReady), 32'd0);
    check("rst_rspvalid", 32'(host_rspValid), 32'd0);
    check("rst_rspdata",  32'(host_rspData),  32'd0);
    base = tck_total;
    n0   = rsp_cnt;
    host_rstn = 1'b1;
    n = 0;
    while (n < 500) begin
      @(posedge host_clk);
      n++;
      @(negedge host_clk);
      if (host_cmdReady) break;
    end
    check("rst_ready_cycle", 32'(n), 32'(12 * C + 1));
    check("rst_tck_count",   32'(tck_total - base), 32'd6);
    check("rst_tms_seq",     tms_bits(base, 6), 32'h1F);
    check("rst_no_rsp",      32'(rsp_cnt - n0), 32'd0);
  endtask

  // Called at a negedge; leaves cmdValid asserted, returns at the negedge
  // after the accepting edge.
  task automatic send_cmd(input logic [1:0] t, input logic [3:0] l,
                          input logic [15:0] d, input logic [15:0] exp);
    int k;
    host_cmdValid = 1'b1;
    host_cmdType  = t;
    host_cmdLen   = l;
    host_cmdData  = d;
    for (k = 0; k < 3000; k++) begin
      if (host_cmdReady) begin
        acc_cyc = cyc + 1;
        exp_q.push_back(exp);
        @(negedge host_clk);
        return;
      end
      @(negedge host_clk);
    end
    check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rsp(input int target);
    int k;
    for (k = 0; k < 3000 && rsp_cnt < target; k++) @(negedge host_clk);
    if (rsp_cnt < target) check("rsp_timeout", 32'(rsp_cnt), 32'(target));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int n0;
    int k;
    int acc1;
    logic [3:0]  rl;
    logic [15:0] rd;
    logic [31:0] full;
    logic [31:0] mask;

    host_rstn     = 1'b0;
    host_cmdValid = 1'b0;
    host_cmdType  = 2'b00;
    host_cmdLen   = 4'd0;
    host_cmdData  = 16'd0;

    // Power-on reset sequence.
    reset_seq();

    // SHIFT_DR 8 bits of 0xA5.
    base = tck_total; n0 = rsp_cnt;
    send_cmd(2'b10, 4'd7, 16'h00A5, 16'h003C);
    host_cmdValid = 1'b0;
    acc1 = acc_cyc;
    wait_rsp(n0 + 1);
    check("dr_latency", 32'(rsp_cyc_log[n0 % 64] - acc1), 32'(2 * C * 13 + 1));
    check("dr_tck_count", 32'(tck_total - base), 32'd13);
    check("dr_tms_seq",   tms_bits(base, 13), 32'h0C01);
    check("dr_tdi_seq",   tdi_bits(base, 13), 32'h00A5 << 3);

    // SHIFT_IR 4 bits of 0xE.
    @(negedge host_clk);
    base = tck_total; n0 = rsp_cnt;
    send_cmd(2'b01, 4'd3, 16'h000E, 16'h0001);
    host_cmdValid = 1'b0;
    wait_rsp(n0 + 1);
    check("ir_tck_count", 32'(tck_total - base), 32'd10);
    check("ir_tms_seq",   tms_bits(base, 10), 32'h0183);
    check("ir_model_reg", 32'(ir), 32'hE);

    // Length boundaries with TDO tied high.
    tdo_tie = 1'b1;
    @(negedge host_clk);
    base = tck_total; n0 = rsp_cnt;
    send_cmd(2'b10, 4'd15, 16'($urandom_range(0, 65535)), 16'hFFFF);
    host_cmdValid = 1'b0;
    wait_rsp(n0 + 1);
    check("len16_tck_count", 32'(tck_total - base), 32'd21);
    @(negedge host_clk);
    base = tck_total; n0 = rsp_cnt;
    send_cmd(2'b10, 4'd0, 16'($urandom_range(0, 65535)), 16'h0001);
    host_cmdValid = 1'b0;
    wait_rsp(n0 + 1);
    check("len1_tck_count", 32'(tck_total - base), 32'd6);
    tdo_tie = 1'b0;

    // Random DR shifts through the model: 0x3C followed by the shifted-in bits.
    for (int i = 0; i < 4; i++) begin
      rl   = 4'($urandom_range(0, 15));
      rd   = 16'($urandom_range(0, 65535));
      full = {16'h0, rd[7:0], 8'h3C};
      mask = (32'd1 << (32'(rl) + 1)) - 1;
      @(negedge host_clk);
      base = tck_total; n0 = rsp_cnt;
      send_cmd(2'b10, rl, rd, 16'(full & mask));
      host_cmdValid = 1'b0;
      wait_rsp(n0 + 1);
      check("rnd_tck_count", 32'(tck_total - base), 32'(rl) + 6);
    end

    // RESET command returns rspData 0 after 6 TCKs.
    @(negedge host_clk);
    base = tck_total; n0 = rsp_cnt;
    send_cmd(2'b00, 4'd0, 16'h0000, 16'h0000);
    host_cmdValid = 1'b0;
    wait_rsp(n0 + 1);
    check("rstcmd_tck_count", 32'(tck_total - base), 32'd6);
    check("rstcmd_tms_seq",   tms_bits(base, 6), 32'h1F);

    // Reset asserted during the 4th shift TCK of a DR command.
    @(negedge host_clk);
    base = tck_total; n0 = rsp_cnt;
    send_cmd(2'b10, 4'd7, 16'h00A5, 16'h003C);
    host_cmdValid = 1'b0;
    for (k = 0; k < 1000 && (tck_total - base) < 7; k++) @(negedge host_clk);
    check("abort_reached", 32'(tck_total - base), 32'd7);
    check("abort_pre_tck", 32'(host_tck), 32'd1);
    host_rstn = 1'b0;
    #1;
    check("abort_tck",   32'(host_tck),      32'd0);
    check("abort_tms",   32'(host_tms),      32'd1);
    check("abort_ready", 32'(host_cmdReady), 32'd0);
    exp_q.delete();
    reset_seq();
    check("abort_no_rsp", 32'(rsp_cnt - n0), 32'd0);

    // Back-to-back: DR then reserved, cmdValid held high throughout.
    base = tck_total; n0 = rsp_cnt;
    send_cmd(2'b10, 4'd7, 16'h005A, 16'h003C);
    acc1 = acc_cyc;
    send_cmd(2'b11, 4'd9, 16'h1234, 16'h0000);
    host_cmdValid = 1'b0;
    wait_rsp(n0 + 2);
    check("b2b_dr_latency",   32'(rsp_cyc_log[n0 % 64] - acc1), 32'(2 * C * 13 + 1));
    check("b2b_accept_cycle", 32'(acc_cyc - rsp_cyc_log[n0 % 64]), 32'd1);
    check("rsvd_latency",     32'(rsp_cyc_log[(n0 + 1) % 64] - acc_cyc), 32'd1);
    check("rsvd_no_tck",      32'(tck_total - base), 32'd13);

    repeat (10) @(negedge host_clk);
    check("final_no_extra_rsp", 32'(rsp_cnt - n0), 32'd2);
    check("final_queue_empty",  32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
